mailbox_result_reader: RTL and testbench



---
 rtl/mailbox_pkg.sv | 15 +
 rtl/sat_counter.sv | 36 +++
 rtl/mailbox_result_reader.sv | 141 ++++++++++++++
 tb/tb_mailbox_result_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared mailbox definitions: reader FSM encoding and default mailbox word addresses.
package mailbox_pkg;

  typedef logic [1:0] mbox_state_t;

  localparam mbox_state_t ST_IDLE      = 2'd0;
  localparam mbox_state_t ST_WAIT_DONE = 2'd1;
  localparam mbox_state_t ST_PRESENT   = 2'd2;
  localparam mbox_state_t ST_CLEAR     = 2'd3;

  localparam logic [31:0] MBOX_N_ADR    = 32'h0200_0000;
  localparam logic [31:0] MBOX_SUM_ADR  = 32'h0200_0004;
  localparam logic [31:0] MBOX_DONE_ADR = 32'h0200_0008;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-value match flag.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         at_term_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/mailbox_result_reader.sv
// Snoops CPU stores for the mailbox result and done flag, hands the result to the host,
// then clears the done flag through the external write port.
module mailbox_result_reader
  import mailbox_pkg::*;
#(
  parameter logic [31:0] RESULT_ADR     = MBOX_SUM_ADR,
  parameter logic [31:0] DONE_ADR       = MBOX_DONE_ADR,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_nores,
  output logic             timeout,
  output logic             busy,
  output logic             Ext_MemWrite,
  output logic [31:0]      Ext_WriteData,
  output logic [31:0]      Ext_DataAdr
);

  // One counter serves both the run length and the timeout, so it must be wide enough
  // for whichever is larger; res_cycles is clamped back to CNT_W bits.
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CW   = (TO_W > CNT_W) ? TO_W : CNT_W;

  mbox_state_t      state_q, state_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
  logic             res_nores_q, res_nores_d;
  logic             got_result_q, got_result_d;
  logic             timeout_q, timeout_d;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CNT_W-1:0] cycles_sat;
  logic             cnt_at_term;
  logic             cnt_clear;
  logic             res_store;
  logic             done_store;

  assign cnt_clear  = (state_q == ST_IDLE) && start;
  assign res_store  = MemWrite && (DataAdr == RESULT_ADR);
  assign done_store = MemWrite && (DataAdr == DONE_ADR) && (WriteData == 32'd1);

  sat_counter #(
    .W (CW)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .en_i      (state_q == ST_WAIT_DONE),
    .term_i    (CW'(TIMEOUT_CYCLES - 1)),
    .count_o   (cnt),
    .at_term_o (cnt_at_term)
  );

  assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;
  assign cycles_sat = (cnt_inc > CW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];

  always_comb begin
    state_d      = state_q;
    res_data_d   = res_data_q;
    res_cycles_d = res_cycles_q;
    res_nores_d  = res_nores_q;
    got_result_d = got_result_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          res_data_d   = '0;
          res_nores_d  = 1'b0;
          got_result_d = 1'b0;
          state_d      = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (res_store) begin
          res_data_d   = WriteData;
          got_result_d = 1'b1;
        end
        // A done store beats a simultaneous timeout.
        if (done_store) begin
          res_cycles_d = cycles_sat;
          res_nores_d  = !got_result_q;
          state_d      = ST_PRESENT;
        end else if (cnt_at_term) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (res_ready) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      res_data_q   <= '0;
      res_cycles_q <= '0;
      res_nores_q  <= 1'b0;
      got_result_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_data_q   <= res_data_d;
      res_cycles_q <= res_cycles_d;
      res_nores_q  <= res_nores_d;
      got_result_q <= got_result_d;
      timeout_q    <= timeout_d;
    end
  end

  assign res_valid     = (state_q == ST_PRESENT);
  assign res_data      = res_data_q;
  assign res_cycles    = res_cycles_q;
  assign res_nores     = res_nores_q;
  assign timeout       = timeout_q;
  assign busy          = (state_q != ST_IDLE);
  assign Ext_MemWrite  = (state_q == ST_CLEAR);
  assign Ext_DataAdr   = (state_q == ST_CLEAR) ? DONE_ADR : 32'd0;
  assign Ext_WriteData = 32'd0;

endmodule

// File: tb/tb_mailbox_result_reader.sv
// Scoreboard bench: two readers (16-bit and 4-bit cycle counters) share the snooped bus.
module tb_mailbox_result_reader;

  localparam logic [31:0] N_ADR    = 32'h0200_0000;
  localparam logic [31:0] SUM_ADR  = 32'h0200_0004;
  localparam logic [31:0] DONE_ADR = 32'h0200_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        res_ready = 1'b0;

  logic        res_valid, res_nores, timeout, busy, Ext_MemWrite;
  logic [31:0] res_data, Ext_WriteData, Ext_DataAdr;
  logic [15:0] res_cycles;

  logic        res_valid_s, res_nores_s, timeout_s, busy_s, Ext_MemWrite_s;
  logic [31:0] res_data_s, Ext_WriteData_s, Ext_DataAdr_s;
  logic [3:0]  res_cycles_s;

  mailbox_result_reader #(
    .CNT_W          (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .MemWrite      (MemWrite),
    .DataAdr       (DataAdr),
    .WriteData     (WriteData),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_cycles    (res_cycles),
    .res_nores     (res_nores),
    .timeout       (timeout),
    .busy          (busy),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_WriteData (Ext_WriteData),
    .Ext_DataAdr   (Ext_DataAdr)
  );

  mailbox_result_reader #(
    .CNT_W          (4),
    .TIMEOUT_CYCLES (64)
  ) dut_s (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .MemWrite      (MemWrite),
    .DataAdr       (DataAdr),
    .WriteData     (WriteData),
    .res_valid     (res_valid_s),
    .res_ready     (res_ready),
    .res_data      (res_data_s),
    .res_cycles    (res_cycles_s),
    .res_nores     (res_nores_s),
    .timeout       (timeout_s),
    .busy          (busy_s),
    .Ext_MemWrite  (Ext_MemWrite_s),
    .Ext_WriteData (Ext_WriteData_s),
    .Ext_DataAdr   (Ext_DataAdr_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] cyc;
    logic        nores;
    logic [3:0]  cyc_s;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   errors = 0;
  int   stage = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void expect_res(logic [31:0] d, int c, logic n);
    exp_t e;
    e.data  = d;
    e.cyc   = 16'(c);
    e.nores = n;
    e.cyc_s = (c > 15) ? 4'hf : 4'(c);
    exp_q.push_back(e);
  endfunction

  // Monitor: scores each accepted result and the one-cycle clear write that follows it.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      case (stage)
        1: begin
          check("ext_we", 32'(Ext_MemWrite), 32'd1);
          check("ext_adr", Ext_DataAdr, DONE_ADR);
          check("ext_data", Ext_WriteData, 32'd0);
          stage = 2;
        end
        2: begin
          check("ext_we_off", 32'(Ext_MemWrite), 32'd0);
          check("busy_after_clear", 32'(busy), 32'd0);
          stage = 0;
        end
        default: if (Ext_MemWrite) check("ext_unexpected", 32'(Ext_MemWrite), 32'd0);
      endcase
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("result_unexpected", 32'(res_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_cycles", 32'(res_cycles), 32'(e.cyc));
          check("res_nores", 32'(res_nores), 32'(e.nores));
          check("res_cycles_sat", 32'(res_cycles_s), 32'(e.cyc_s));
          check("res_valid_sat", 32'(res_valid_s), 32'd1);
        end
        stage = 1;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(logic [31:0] adr, logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    tick(1);
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      tick(1);
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(string name);
    check({name, "_valid"}, 32'(res_valid), 32'd0);
    check({name, "_data"}, res_data, 32'd0);
    check({name, "_cycles"}, 32'(res_cycles), 32'd0);
    check({name, "_nores"}, 32'(res_nores), 32'd0);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_ext_we"}, 32'(Ext_MemWrite), 32'd0);
    check({name, "_ext_adr"}, Ext_DataAdr, 32'd0);
    check({name, "_cycles_sat"}, 32'(res_cycles_s), 32'd0);
  endtask

  initial begin
    logic [31:0] acc;

    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Sum of 1..10 written progressively by the CPU; done lands on edge 12.
    res_ready = 1'b1;
    do_start();
    store(N_ADR, 32'd10);
    acc = 0;
    for (int i = 1; i <= 10; i++) begin
      acc = acc + 32'(i);
      store(SUM_ADR, acc);
    end
    expect_res(32'd55, 12, 1'b0);
    store(DONE_ADR, 32'd1);
    check("sum_valid_latency", 32'(res_valid), 32'd1);
    wait_idle("sum_idle");
    tick(2);

    // Backpressure: result must stay presented until the host accepts.
    res_ready = 1'b0;
    do_start();
    store(SUM_ADR, 32'd7);
    expect_res(32'd7, 2, 1'b0);
    store(DONE_ADR, 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", res_data, 32'd7);
      tick(1);
    end
    res_ready = 1'b1;
    wait_idle("bp_idle");
    tick(2);

    // Last write wins.
    do_start();
    store(SUM_ADR, 32'd3);
    store(SUM_ADR, 32'd9);
    expect_res(32'd9, 3, 1'b0);
    store(DONE_ADR, 32'd1);
    wait_idle("lww_idle");
    tick(2);

    // Done without any result store; res_data cleared at start.
    do_start();
    expect_res(32'd0, 1, 1'b1);
    store(DONE_ADR, 32'd1);
    wait_idle("nores_idle");
    tick(2);

    // Timeout: DONE=2 ignored, pulse visible only after edge 64.
    do_start();
    tick(4);
    store(DONE_ADR, 32'd2);
    for (int e = 6; e <= 70; e++) begin
      tick(1);
      check("to_pulse", 32'(timeout), 32'(e == 64));
      check("to_busy", 32'(busy), 32'(e < 64));
    end
    tick(2);

    // 37-edge run with start abuse at edge 10; 4-bit copy saturates.
    do_start();
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(26);
    expect_res(32'd0, 37, 1'b1);
    store(DONE_ADR, 32'd1);
    wait_idle("c37_idle");
    tick(2);

    // 40-edge run.
    do_start();
    store(SUM_ADR, 32'd1);
    tick(38);
    expect_res(32'd1, 40, 1'b0);
    store(DONE_ADR, 32'd1);
    wait_idle("c40_idle");
    tick(2);

    // Reset while presenting: result dropped, no clear write.
    res_ready = 1'b0;
    do_start();
    store(SUM_ADR, 32'd5);
    store(DONE_ADR, 32'd1);
    check("rst_pre_valid", 32'(res_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    check_all_zero("rst_present");
    reset = 1'b0;
    tick(5);
    check("rst_post_busy", 32'(busy), 32'd0);
    res_ready = 1'b1;
    tick(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
